// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the writeback stage.
//   stat_t  : architectural status codes (AOK=1, HLT=2, ADR=3, INS=4)
//   icode_t : instruction codes
//   RNONE   : register index meaning "no register" at the 4-bit index width
package y86_pkg;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic [3:0] {
        ICODE_HALT   = 4'h0,
        ICODE_NOP    = 4'h1,
        ICODE_RRMOVQ = 4'h2,
        ICODE_IRMOVQ = 4'h3,
        ICODE_RMMOVQ = 4'h4,
        ICODE_MRMOVQ = 4'h5,
        ICODE_OPQ    = 4'h6,
        ICODE_JXX    = 4'h7,
        ICODE_CALL   = 4'h8,
        ICODE_RET    = 4'h9,
        ICODE_PUSHQ  = 4'hA,
        ICODE_POPQ   = 4'hB
    } icode_t;

    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/wb_stat_encode.sv
// Combinational status encoder for one instruction.
// Priority: address error (fetch or data) -> ADR, then illegal -> INS,
// then halt -> HLT, otherwise AOK.
// Ports:
//   imem_error_i, dmem_error_i : address errors
//   instr_valid_i, instr_error_i : decoder legality flags
//   hlt_i : instruction is halt
//   stat_o : resulting status
module wb_stat_encode
    import y86_pkg::*;
(
    input  logic  imem_error_i,
    input  logic  dmem_error_i,
    input  logic  instr_valid_i,
    input  logic  instr_error_i,
    input  logic  hlt_i,
    output stat_t stat_o
);

    always_comb begin
        if (imem_error_i || dmem_error_i)
            stat_o = STAT_ADR;
        else if (!instr_valid_i || instr_error_i)
            stat_o = STAT_INS;
        else if (hlt_i)
            stat_o = STAT_HLT;
        else
            stat_o = STAT_AOK;
    end

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: registers one instruction per cycle from the memory
// stage, drives the E and M register-file write ports one cycle later, tracks
// the final machine status and counts retired instructions.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   m_valid_i / wb_ready_o  : handshake with memory stage (ready only in RUN)
//   icode_i, dstE_i, dstM_i, valE_i, valM_i : instruction payload
//   instr_valid_i, instr_error_i, imem_error_i, dmem_error_i, hlt_i : status flags
//   rf_wrE_*, rf_wrM_*      : register-file write ports
//   stat_o, halted_o        : machine status, stopped indication
//   retired_cnt_o           : saturating retired-instruction count
// Optional build macro WB_FWD_EN adds fwdE_*/fwdM_* outputs that mirror the
// write ports for decode-stage forwarding.
module writeback_stage
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int RA_W   = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m_valid_i,
    output logic              wb_ready_o,
    input  logic [3:0]        icode_i,
    input  logic [RA_W-1:0]   dstE_i,
    input  logic [RA_W-1:0]   dstM_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [DATA_W-1:0] valM_i,
    input  logic              instr_valid_i,
    input  logic              instr_error_i,
    input  logic              imem_error_i,
    input  logic              dmem_error_i,
    input  logic              hlt_i,
    output logic              rf_wrE_en_o,
    output logic [RA_W-1:0]   rf_wrE_addr_o,
    output logic [DATA_W-1:0] rf_wrE_data_o,
    output logic              rf_wrM_en_o,
    output logic [RA_W-1:0]   rf_wrM_addr_o,
    output logic [DATA_W-1:0] rf_wrM_data_o,
    output logic [2:0]        stat_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_cnt_o
`ifdef WB_FWD_EN
    ,
    output logic              fwdE_valid_o,
    output logic [RA_W-1:0]   fwdE_dst_o,
    output logic [DATA_W-1:0] fwdE_val_o,
    output logic              fwdM_valid_o,
    output logic [RA_W-1:0]   fwdM_dst_o,
    output logic [DATA_W-1:0] fwdM_val_o
`endif
);

    typedef enum logic [1:0] {RUN, HALTED, FAULT} wb_state_t;

    localparam logic [RA_W-1:0] REG_NONE = {RA_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    wb_state_t         state;
    stat_t             stat_in;
    stat_t             stat_q;
    logic              accept;
    logic              retires;
    logic              wr_ok;
    logic [CNT_W-1:0]  cnt_q;

    logic              w_vld_p1;
    stat_t             w_stat_p1;
    logic [RA_W-1:0]   w_dstE_p1;
    logic [RA_W-1:0]   w_dstM_p1;
    logic [DATA_W-1:0] w_valE_p1;
    logic [DATA_W-1:0] w_valM_p1;

    // icode does not influence writeback; kept on the port for interface symmetry
    logic unused_icode;
    assign unused_icode = ^icode_i;

    wb_stat_encode u_stat (
        .imem_error_i  (imem_error_i),
        .dmem_error_i  (dmem_error_i),
        .instr_valid_i (instr_valid_i),
        .instr_error_i (instr_error_i),
        .hlt_i         (hlt_i),
        .stat_o        (stat_in)
    );

    assign wb_ready_o = (state == RUN);
    assign accept     = m_valid_i && wb_ready_o;
    assign retires    = (stat_in == STAT_AOK) || (stat_in == STAT_HLT);

    // ---- stage boundary: memory -> W register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            stat_q    <= STAT_AOK;
            cnt_q     <= '0;
            w_vld_p1  <= 1'b0;
            w_stat_p1 <= STAT_AOK;
            w_dstE_p1 <= REG_NONE;
            w_dstM_p1 <= REG_NONE;
            w_valE_p1 <= '0;
            w_valM_p1 <= '0;
        end else begin
            w_vld_p1 <= accept;
            if (accept) begin
                w_stat_p1 <= stat_in;
                w_dstE_p1 <= dstE_i;
                w_dstM_p1 <= dstM_i;
                w_valE_p1 <= valE_i;
                w_valM_p1 <= valM_i;
                stat_q    <= stat_in;
                if (retires)
                    cnt_q <= sat_inc(cnt_q);
                case (stat_in)
                    STAT_HLT:           state <= HALTED;
                    STAT_ADR, STAT_INS: state <= FAULT;
                    default:            state <= state;
                endcase
            end
        end
    end

    // ---- stage boundary: W register -> register file ----
    // When both destinations name the same register (popq %rsp) only M writes.
    assign wr_ok         = w_vld_p1 && (w_stat_p1 == STAT_AOK);
    assign rf_wrM_en_o   = wr_ok && (w_dstM_p1 != REG_NONE);
    assign rf_wrE_en_o   = wr_ok && (w_dstE_p1 != REG_NONE) && (w_dstE_p1 != w_dstM_p1);
    assign rf_wrE_addr_o = w_dstE_p1;
    assign rf_wrE_data_o = w_valE_p1;
    assign rf_wrM_addr_o = w_dstM_p1;
    assign rf_wrM_data_o = w_valM_p1;

    assign stat_o        = stat_q;
    assign halted_o      = (state != RUN);
    assign retired_cnt_o = cnt_q;

`ifdef WB_FWD_EN
    assign fwdE_valid_o = rf_wrE_en_o;
    assign fwdE_dst_o   = rf_wrE_addr_o;
    assign fwdE_val_o   = rf_wrE_data_o;
    assign fwdM_valid_o = rf_wrM_en_o;
    assign fwdM_dst_o   = rf_wrM_addr_o;
    assign fwdM_val_o   = rf_wrM_data_o;
`endif

endmodule
